fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised, pipelined floating-point add/subtract unit; successor to the fixed
//  3-bit-exp/4-bit-frac combinational adder. Accepts one operand pair per cycle over
//  valid/ready, returns a normalised result 3 cycles later. Sits between the operand
//  register file and the FP result bus; generalised widths, backpressure, ovf/zero flags.
// PARAMETERS
//  EXP_W   5   exponent width, biased by 2**(EXP_W-1)-1; all-ones exponent = overflow/inf
//  FRAC_W  10  stored fraction width; hidden 1 implied for non-zero operands
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        unit accepts pair this cycle
//  in_op      in   1        0 = A+B, 1 = A-B
//  a_sign/b_sign in 1       operand signs
//  a_exp/b_exp   in EXP_W   operand biased exponents
//  a_frac/b_frac in FRAC_W  operand fractions
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_sign   out  1        result sign
//  out_exp    out  EXP_W    result exponent
//  out_frac   out  FRAC_W   result fraction
//  out_ovf    out  1        exponent overflow, result saturated
//  out_zero   out  1        exact zero or underflow flush
// BEHAVIOUR
//  - Reset: all stage valids 0; out_valid, out_sign, out_exp, out_frac, out_ovf, out_zero = 0.
//  - Handshake: advance = out_ready | ~out_valid; in_ready = advance (combinational). All
//    stages shift together on advance, hold otherwise. Transfer only when valid&ready.
//    Latency exactly 3 cycles when unstalled; throughput 1/cycle; order preserved.
//  - Output held stable while out_valid & ~out_ready.
//  - Zero encoding: exp==0 & frac==0 (hidden bit 0); other exp==0 codes treated as normal.
//  - S1 align: eff_sub = in_op ^ a_sign ^ b_sign. Larger = greater {exp,frac} (tie: A).
//    Smaller mantissa {1,frac} right-shifted by exp diff into FRAC_W+4 bits (guard, round,
//    sticky); diff >= FRAC_W+3 -> smaller reduces to sticky only.
//  - S2 add: FRAC_W+5-bit add or subtract (larger - smaller, never negative).
//    Sign = larger's sign (B's sign inverted when in_op=1 and B larger).
//  - S3 normalise: carry out -> shift right 1, exp+1 (shifted-out bit ORed into sticky);
//    else leading-zero count lz, shift left lz, exp-lz. Rounding per CONFIGURATION.
//  - Exact cancellation (result 0): out_sign=0, exp=0, frac=0, out_zero=1.
//  - Underflow (exp-lz < 1 for non-zero): flush to +/-0 per sign, out_zero=1.
//  - Overflow (final exp >= all-ones) or any input exp all-ones: exp=all-ones, frac=0,
//    out_ovf=1, sign per S2 rule.
//  - Reset asserted mid-operation: in-flight results discarded, no partial output.
// CONFIGURATION
//  ROUND_NEAREST_EN defined: round-to-nearest-even from guard/round/sticky; rounding carry
//    renormalises (exp+1) and may itself raise out_ovf.
//  ROUND_NEAREST_EN undefined: truncation; guard/round/sticky discarded, rounding adder absent.
// TESTING (defaults EXP_W=5, FRAC_W=10, bias 15)
//  1. A=(0,15,0x000) + B=(0,15,0x000), op=0 -> after 3 cycles (0,16,0x000), flags 0.
//  2. A=(0,15,0x200) - B=(0,15,0x200) -> (0,0,0x000), out_zero=1.
//  3. A=(0,30,0x3FF) + B=(0,30,0x3FF) -> (0,31,0x000), out_ovf=1.
//  4. A=(0,15,0x000) + B=(0,4,0x200): with ROUND_NEAREST_EN -> (0,15,0x001); without -> (0,15,0x000).
//  5. Stream 5 pairs, out_ready=0 after 3 accepted: in_ready=0, out_* stable; release ->
//     remaining results in order, one per cycle, none lost or duplicated.
//  6. rst_n low for 1 cycle with 3 in flight -> out_valid=0 and outputs 0 immediately;
//     first post-reset pair emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point add/subtract with valid/ready flow
// control, overflow saturation and zero/underflow flush.
// Optional feature macro: ROUND_NEAREST_EN (round-to-nearest-even; default is truncation).
module fp_addsub_pipe #(
    parameter int unsigned EXP_W  = 5,
    parameter int unsigned FRAC_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] b_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_ovf,
    output logic              out_zero
);
    // Mantissa datapath: hidden bit, fraction, guard, round, sticky.
    localparam int unsigned MW  = FRAC_W + 4;
    localparam int unsigned LZW = $clog2(MW);
    // Signed working exponent wide enough for exp+1 and exp-lz.
    localparam int unsigned XW  = EXP_W + LZW + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // ---------------- Stage 1: operand swap and alignment ----------------
    logic              a_zero, b_zero, a_big, l_sign, eff_sub, in_inf;
    logic [FRAC_W:0]   a_mant, b_mant, l_mant, s_mant;
    logic [EXP_W-1:0]  l_exp, diff;
    logic [MW-1:0]     s_ext, s_shift, s_mask, s_algn;

    // Pick the larger operand and shift the smaller one into guard/round/sticky.
    always_comb begin
        a_zero  = (a_exp == '0) && (a_frac == '0);
        b_zero  = (b_exp == '0) && (b_frac == '0);
        a_mant  = {~a_zero, a_frac};
        b_mant  = {~b_zero, b_frac};
        a_big   = {a_exp, a_frac} >= {b_exp, b_frac};
        eff_sub = in_op ^ a_sign ^ b_sign;
        in_inf  = (a_exp == EXP_MAX) || (b_exp == EXP_MAX);
        if (a_big) begin
            l_mant = a_mant;
            s_mant = b_mant;
            l_exp  = a_exp;
            diff   = a_exp - b_exp;
            l_sign = a_sign;
        end else begin
            l_mant = b_mant;
            s_mant = a_mant;
            l_exp  = b_exp;
            diff   = b_exp - a_exp;
            l_sign = b_sign ^ in_op;
        end
        s_ext   = {s_mant, 3'b000};
        s_shift = s_ext >> diff;
        s_mask  = (MW'(1) << diff) - MW'(1);
        if (32'(diff) >= FRAC_W + 3) begin
            s_algn = {{(MW-1){1'b0}}, |s_mant};
        end else begin
            s_algn = s_shift | {{(MW-1){1'b0}}, |(s_ext & s_mask)};
        end
    end

    logic              s1_valid, s1_sign, s1_sub, s1_inf;
    logic [EXP_W-1:0]  s1_exp;
    logic [MW-1:0]     s1_big, s1_small;

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sub   <= 1'b0;
            s1_inf   <= 1'b0;
            s1_exp   <= '0;
            s1_big   <= '0;
            s1_small <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_sign  <= l_sign;
            s1_sub   <= eff_sub;
            s1_inf   <= in_inf;
            s1_exp   <= l_exp;
            s1_big   <= {l_mant, 3'b000};
            s1_small <= s_algn;
        end
    end

    // ---------------- Stage 2: magnitude add/subtract ----------------
    logic [MW:0] sum;

    // Larger minus smaller never goes negative.
    always_comb begin
        if (s1_sub) sum = {1'b0, s1_big} - {1'b0, s1_small};
        else        sum = {1'b0, s1_big} + {1'b0, s1_small};
    end

    logic              s2_valid, s2_sign, s2_inf;
    logic [EXP_W-1:0]  s2_exp;
    logic [MW:0]       s2_sum;

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_inf   <= 1'b0;
            s2_exp   <= '0;
            s2_sum   <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_inf   <= s1_inf;
            s2_exp   <= s1_exp;
            s2_sum   <= sum;
        end
    end

    // ---------------- Stage 3: normalise, round, classify ----------------
    logic                    found, unused_bits;
    logic [LZW-1:0]          lz;
    logic [MW-1:0]           norm;
    logic signed [XW-1:0]    exp_x, exp_r;
    logic [FRAC_W-1:0]       frac_r;
    logic                    n_sign, n_ovf, n_zero;
    logic [EXP_W-1:0]        n_exp;
    logic [FRAC_W-1:0]       n_frac;
`ifdef ROUND_NEAREST_EN
    logic                    round_up;
    logic [FRAC_W+1:0]       mant_r;
`endif

    // Normalise the raw sum and resolve zero, underflow and overflow cases.
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = int'(MW) - 1; i >= 0; i--) begin
            if (!found && s2_sum[i]) begin
                lz    = LZW'(int'(MW) - 1 - i);
                found = 1'b1;
            end
        end
        if (s2_sum[MW]) begin
            norm  = {s2_sum[MW:2], s2_sum[1] | s2_sum[0]};
            exp_x = $signed(XW'(s2_exp) + XW'(1));
        end else begin
            norm  = s2_sum[MW-1:0] << lz;
            exp_x = $signed(XW'(s2_exp) - XW'(lz));
        end
`ifdef ROUND_NEAREST_EN
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[MW-1:3]} + {{(FRAC_W+1){1'b0}}, round_up};
        if (mant_r[FRAC_W+1]) begin
            frac_r = '0;
            exp_r  = exp_x + $signed(XW'(1));
        end else begin
            frac_r = mant_r[FRAC_W-1:0];
            exp_r  = exp_x;
        end
        unused_bits = mant_r[FRAC_W] ^ norm[MW-1];
`else
        frac_r      = norm[FRAC_W+2:3];
        exp_r       = exp_x;
        unused_bits = ^{norm[MW-1], norm[2:0]};
`endif
        n_sign = s2_sign;
        n_exp  = '0;
        n_frac = '0;
        n_ovf  = 1'b0;
        n_zero = 1'b0;
        if (s2_inf) begin
            n_exp = EXP_MAX;
            n_ovf = 1'b1;
        end else if (s2_sum == '0) begin
            n_sign = 1'b0;
            n_zero = 1'b1;
        end else if (exp_x < $signed(XW'(1))) begin
            n_zero = 1'b1;
        end else if (exp_r >= $signed(XW'(EXP_MAX))) begin
            n_exp = EXP_MAX;
            n_ovf = 1'b1;
        end else begin
            n_exp  = exp_r[EXP_W-1:0];
            n_frac = frac_r;
        end
    end

    // Output registers; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_sign  <= s2_valid & n_sign;
            out_exp   <= s2_valid ? n_exp : '0;
            out_frac  <= s2_valid ? n_frac : '0;
            out_ovf   <= s2_valid & n_ovf;
            out_zero  <= s2_valid & n_zero;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed-vector bench for fp_addsub_pipe with an exact-arithmetic
// reference model and a scoreboard queue checked on every output transfer.
module tb_fp_addsub_pipe;

    typedef struct packed {
        logic       op;
        logic       as;
        logic [4:0] ae;
        logic [9:0] af;
        logic       bs;
        logic [4:0] be;
        logic [9:0] bf;
    } vec_t;

    typedef struct packed {
        logic [17:0] res;
        int          acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_op = 1'b0;
    logic       a_sign = 1'b0, b_sign = 1'b0;
    logic [4:0] a_exp = '0, b_exp = '0;
    logic [9:0] a_frac = '0, b_frac = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_sign, out_ovf, out_zero;
    logic [4:0] out_exp;
    logic [9:0] out_frac;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          lat_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [17:0] prev_out;
    logic [17:0] got;
    exp_t        cur;
    exp_t        q[$];
    vec_t        vecs[19];

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_frac    (a_frac),
        .b_sign    (b_sign),
        .b_exp     (b_exp),
        .b_frac    (b_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact reference: operands as integers mant*2^exp, sum exactly, then normalise/round.
    function automatic logic [17:0] model(input vec_t v);
        longint ma, mb, va, vb, r, mag, q_m, rem, half;
        int     p, e;
        logic   s2sign, sign;
        ma = (v.ae == 0 && v.af == 0) ? 64'd0 : longint'(1024 + int'(v.af));
        mb = (v.be == 0 && v.bf == 0) ? 64'd0 : longint'(1024 + int'(v.bf));
        va = ma << v.ae;
        vb = mb << v.be;
        if (v.as) va = -va;
        if (v.bs ^ v.op) vb = -vb;
        s2sign = ({v.ae, v.af} >= {v.be, v.bf}) ? v.as : (v.bs ^ v.op);
        if (v.ae == 5'd31 || v.be == 5'd31) return {s2sign, 5'd31, 10'd0, 2'b10};
        r = va + vb;
        if (r == 0) return {1'b0, 5'd0, 10'd0, 2'b01};
        sign = (r < 0);
        mag  = sign ? -r : r;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = p - 10;
        if (e < 1) return {sign, 5'd0, 10'd0, 2'b01};
        q_m = mag >> (p - 10);
        rem = mag - (q_m << (p - 10));
        half = longint'(1) << (p - 11);
`ifdef ROUND_NEAREST_EN
        if (rem > half || (rem == half && q_m[0])) q_m = q_m + 1;
        if (q_m == 2048) begin
            q_m = 1024;
            e = e + 1;
        end
`else
        if (rem < 0 || half < 0) q_m = 0;
`endif
        if (e >= 31) return {sign, 5'd31, 10'd0, 2'b10};
        return {sign, e[4:0], q_m[9:0], 2'b00};
    endfunction

    function automatic vec_t mk(input logic op, input logic as, input logic [4:0] ae,
                                input logic [9:0] af, input logic bs, input logic [4:0] be,
                                input logic [9:0] bf);
        vec_t v;
        v = '{op: op, as: as, ae: ae, af: af, bs: bs, be: be, bf: bf};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        tests++;
        if (actual !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, actual, want, cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op = v.op;
        a_sign = v.as; a_exp = v.ae; a_frac = v.af;
        b_sign = v.bs; b_exp = v.be; b_frac = v.bf;
    endtask

    // Present a pair and return 1 time unit after the edge that accepted it.
    task automatic send(input vec_t v);
        bit ok;
        bit done;
        done = 1'b0;
        drive(v);
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stuck low, expected acceptance within 50 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            got = {out_sign, out_exp, out_frac, out_ovf, out_zero};
            if (prev_stall) check("hold_stable", {out_valid, got}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_out: got result %h, expected no output", got);
                end else begin
                    cur = q.pop_front();
                    check("result", got, cur.res);
                    if (lat_en) check("latency", cyc - cur.acc, 3);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{res: model({in_op, a_sign, a_exp, a_frac, b_sign, b_exp, b_frac}),
                              acc: cyc});
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        vecs[0]  = mk(0, 0, 15, 10'h000, 0, 15, 10'h000);
        vecs[1]  = mk(1, 0, 15, 10'h200, 0, 15, 10'h200);
        vecs[2]  = mk(0, 0, 30, 10'h3FF, 0, 30, 10'h3FF);
        vecs[3]  = mk(0, 0, 15, 10'h000, 0, 4, 10'h200);
        vecs[4]  = mk(1, 0, 15, 10'h000, 0, 16, 10'h000);
        vecs[5]  = mk(0, 1, 20, 10'h155, 0, 18, 10'h0AA);
        vecs[6]  = mk(0, 0, 15, 10'h000, 1, 15, 10'h3FF);
        vecs[7]  = mk(0, 0, 10, 10'h001, 0, 0, 10'h000);
        vecs[8]  = mk(0, 0, 0, 10'h000, 0, 0, 10'h000);
        vecs[9]  = mk(1, 0, 1, 10'h001, 0, 1, 10'h000);
        vecs[10] = mk(1, 1, 1, 10'h001, 1, 1, 10'h000);
        vecs[11] = mk(0, 0, 31, 10'h000, 0, 3, 10'h100);
        vecs[12] = mk(1, 0, 2, 10'h000, 0, 31, 10'h005);
        vecs[13] = mk(1, 0, 20, 10'h000, 0, 1, 10'h3FF);
        vecs[14] = mk(0, 0, 15, 10'h001, 0, 4, 10'h000);
        vecs[15] = mk(0, 0, 30, 10'h3FF, 0, 19, 10'h3FF);
        vecs[16] = mk(0, 0, 3, 10'h0F0, 1, 3, 10'h0F0);
        vecs[17] = mk(0, 0, 0, 10'h100, 0, 0, 10'h100);
        vecs[18] = mk(0, 1, 12, 10'h2A5, 1, 9, 10'h133);

        // Pin the reference model with hand-computed results.
        check("model_1p1", model(vecs[0]), {1'b0, 5'd16, 10'h000, 2'b00});
        check("model_cancel", model(vecs[1]), {1'b0, 5'd0, 10'h000, 2'b01});
        check("model_ovf", model(vecs[2]), {1'b0, 5'd31, 10'h000, 2'b10});
        check("model_neg", model(vecs[4]), {1'b1, 5'd15, 10'h000, 2'b00});
        check("model_lshift", model(vecs[6]), {1'b1, 5'd14, 10'h3FE, 2'b00});
        check("model_exp0", model(vecs[17]), {1'b0, 5'd1, 10'h100, 2'b00});
`ifdef ROUND_NEAREST_EN
        check("model_round", model(vecs[3]), {1'b0, 5'd15, 10'h001, 2'b00});
        check("model_sticky", model(vecs[13]), {1'b0, 5'd20, 10'h000, 2'b00});
        check("model_tie", model(vecs[14]), {1'b0, 5'd15, 10'h002, 2'b00});
        check("model_rnd_ovf", model(vecs[15]), {1'b0, 5'd31, 10'h000, 2'b10});
`else
        check("model_round", model(vecs[3]), {1'b0, 5'd15, 10'h000, 2'b00});
        check("model_sticky", model(vecs[13]), {1'b0, 5'd19, 10'h3FF, 2'b00});
        check("model_tie", model(vecs[14]), {1'b0, 5'd15, 10'h001, 2'b00});
        check("model_rnd_ovf", model(vecs[15]), {1'b0, 5'd30, 10'h3FF, 2'b00});
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, out_sign, out_exp, out_frac, out_ovf, out_zero}, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors streamed back to back, unstalled.
        lat_en = 1'b1;
        for (int i = 0; i < 19; i++) send(vecs[i]);
        idle();
        drain();

        // Backpressure: stall after three accepted, then release.
        lat_en = 1'b0;
        send(vecs[4]);
        send(vecs[5]);
        send(vecs[6]);
        out_ready = 1'b0;
        drive(vecs[13]);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(vecs[13]);
        send(vecs[15]);
        idle();
        drain();

        // Reset with results in flight.
        lat_en = 1'b1;
        send(vecs[0]);
        send(vecs[2]);
        send(vecs[3]);
        idle();
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midreset_outputs", {out_valid, out_sign, out_exp, out_frac, out_ovf, out_zero}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", out_valid, 0);
        send(vecs[18]);
        idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
